// File: rtl/prog_mem_loader.sv
// Two-wire serial programming loader: writes 12-bit words into program memory and holds the core meanwhile.
// Define LOADER_READBACK_EN to build the READ_DATA command and the serial readback (sdo) path.
`ifndef INST_WIDTH
`define INST_WIDTH 12
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 9
`endif

module prog_mem_loader #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   progEnIn,
    input  logic                   sclkIn,
    input  logic                   sdataIn,
    input  logic [`INST_WIDTH-1:0] memRdDataIn,
    output logic [`PC_WIDTH-1:0]   memAddrOut,
    output logic [`INST_WIDTH-1:0] memWrDataOut,
    output logic                   memWrEnOut,
    output logic                   coreHoldOut,
    output logic                   sdoOut,
    output logic                   sdoOeOut
);

    localparam int IW = `INST_WIDTH;
    localparam int PW = `PC_WIDTH;
    localparam logic [PW-1:0] ADDR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] ADDR_ONE  = {{(PW-1){1'b0}}, 1'b1};

    localparam logic [5:0] CMD_LOAD     = 6'h02;
    localparam logic [5:0] CMD_READ     = 6'h04;
    localparam logic [5:0] CMD_INC      = 6'h06;
    localparam logic [5:0] CMD_BEGIN    = 6'h08;
    localparam logic [5:0] CMD_RST_ADDR = 6'h16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WRITE = 3'd3
`ifdef LOADER_READBACK_EN
        , ST_READ = 3'd4
`endif
    } state_t;

    logic [SYNC_STAGES-1:0] pen_sync_r;
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] sdata_sync_r;
    logic                   sclk_prev_r;
    logic                   pen_s;
    logic                   sclk_s;
    logic                   sdata_s;
    logic                   rise_s;

    state_t          state_r;
    logic [3:0]      bit_cnt_r;
    logic [4:0]      cmd_sr_r;
    logic [5:0]      cmd_next_s;
    logic [IW-1:0]   load_sr_r;
    logic [IW-1:0]   data_r;
    logic [PW-1:0]   addr_r;
    logic            wr_en_r;

    assign pen_s      = pen_sync_r[SYNC_STAGES-1];
    assign sclk_s     = sclk_sync_r[SYNC_STAGES-1];
    assign sdata_s    = sdata_sync_r[SYNC_STAGES-1];
    assign rise_s     = sclk_s & ~sclk_prev_r;
    assign cmd_next_s = {sdata_s, cmd_sr_r};

    // Synchronize the host pins and keep the previous sclk for rise detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            pen_sync_r   <= {SYNC_STAGES{1'b0}};
            sclk_sync_r  <= {SYNC_STAGES{1'b0}};
            sdata_sync_r <= {SYNC_STAGES{1'b0}};
            sclk_prev_r  <= 1'b0;
        end else begin
            pen_sync_r   <= {pen_sync_r[SYNC_STAGES-2:0], progEnIn};
            sclk_sync_r  <= {sclk_sync_r[SYNC_STAGES-2:0], sclkIn};
            sdata_sync_r <= {sdata_sync_r[SYNC_STAGES-2:0], sdataIn};
            sclk_prev_r  <= sclk_s;
        end
    end

`ifdef LOADER_READBACK_EN
    logic [IW:0] rd_sr_r;
    logic        sdo_r;
    logic        sdo_oe_r;
    assign sdoOut   = sdo_r;
    assign sdoOeOut = sdo_oe_r;
`else
    logic unused_rd_s;
    assign unused_rd_s = ^memRdDataIn;
    assign sdoOut      = 1'b0;
    assign sdoOeOut    = 1'b0;
`endif

    // Protocol FSM; a low progEn aborts any frame and drops a pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            cmd_sr_r  <= 5'd0;
            load_sr_r <= {IW{1'b0}};
            data_r    <= {IW{1'b0}};
            addr_r    <= ADDR_ZERO;
            wr_en_r   <= 1'b0;
`ifdef LOADER_READBACK_EN
            rd_sr_r   <= {(IW+1){1'b0}};
            sdo_r     <= 1'b0;
            sdo_oe_r  <= 1'b0;
`endif
        end else if (!pen_s) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            cmd_sr_r  <= 5'd0;
            load_sr_r <= {IW{1'b0}};
            addr_r    <= ADDR_ZERO;
            wr_en_r   <= 1'b0;
`ifdef LOADER_READBACK_EN
            rd_sr_r   <= {(IW+1){1'b0}};
            sdo_r     <= 1'b0;
            sdo_oe_r  <= 1'b0;
`endif
        end else begin
            wr_en_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r   <= ST_CMD;
                    bit_cnt_r <= 4'd0;
                end
                ST_CMD: begin
                    if (rise_s) begin
                        if (bit_cnt_r == 4'd5) begin
                            bit_cnt_r <= 4'd0;
                            cmd_sr_r  <= 5'd0;
                            case (cmd_next_s)
                                CMD_LOAD:     state_r <= ST_LOAD;
`ifdef LOADER_READBACK_EN
                                // Word is captured now; bit0 (a zero) is presented right away.
                                CMD_READ: begin
                                    state_r  <= ST_READ;
                                    rd_sr_r  <= {1'b0, memRdDataIn};
                                    sdo_r    <= 1'b0;
                                    sdo_oe_r <= 1'b1;
                                end
`endif
                                CMD_INC:      addr_r  <= addr_r + ADDR_ONE;
                                CMD_BEGIN:    state_r <= ST_WRITE;
                                CMD_RST_ADDR: addr_r  <= ADDR_ZERO;
                                default:      state_r <= ST_CMD;
                            endcase
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            cmd_sr_r  <= cmd_next_s[5:1];
                        end
                    end
                end
                ST_LOAD: begin
                    if (rise_s) begin
                        if (bit_cnt_r == 4'd13) begin
                            data_r    <= load_sr_r;
                            load_sr_r <= {IW{1'b0}};
                            bit_cnt_r <= 4'd0;
                            state_r   <= ST_CMD;
                        end else begin
                            if (bit_cnt_r != 4'd0) begin
                                load_sr_r <= {sdata_s, load_sr_r[IW-1:1]};
                            end
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    wr_en_r <= 1'b1;
                    state_r <= ST_CMD;
                end
`ifdef LOADER_READBACK_EN
                ST_READ: begin
                    if (rise_s) begin
                        if (bit_cnt_r == 4'd13) begin
                            sdo_r     <= 1'b0;
                            sdo_oe_r  <= 1'b0;
                            bit_cnt_r <= 4'd0;
                            state_r   <= ST_CMD;
                        end else begin
                            sdo_r     <= rd_sr_r[0];
                            rd_sr_r   <= {1'b0, rd_sr_r[IW:1]};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                end
`endif
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign memAddrOut   = addr_r;
    assign memWrDataOut = data_r;
    assign memWrEnOut   = wr_en_r;
    assign coreHoldOut  = pen_s;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: drives the two-wire host protocol and checks writes, address and readback.
module tb_prog_mem_loader;

    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        progEnIn = 1'b0;
    logic        sclkIn = 1'b0;
    logic        sdataIn = 1'b0;
    logic [11:0] memRdDataIn;
    logic [8:0]  memAddrOut;
    logic [11:0] memWrDataOut;
    logic        memWrEnOut;
    logic        coreHoldOut;
    logic        sdoOut;
    logic        sdoOeOut;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int pulse_long = 0;
    logic [8:0]  last_addr = 9'd0;
    logic [11:0] last_data = 12'd0;
    logic        prev_we = 1'b0;

    prog_mem_loader #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .progEnIn     (progEnIn),
        .sclkIn       (sclkIn),
        .sdataIn      (sdataIn),
        .memRdDataIn  (memRdDataIn),
        .memAddrOut   (memAddrOut),
        .memWrDataOut (memWrDataOut),
        .memWrEnOut   (memWrEnOut),
        .coreHoldOut  (coreHoldOut),
        .sdoOut       (sdoOut),
        .sdoOeOut     (sdoOeOut)
    );

    always #5 clk = ~clk;

    // Program memory model: only address 5 holds a nonzero word.
    assign memRdDataIn = (memAddrOut == 9'd5) ? 12'h3C5 : 12'h000;

    // Write strobe monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (memWrEnOut) begin
            wr_count++;
            last_addr = memAddrOut;
            last_data = memWrDataOut;
            if (prev_we) pulse_long++;
        end
        prev_we = memWrEnOut;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, output logic s_sdo, output logic s_oe);
        sdataIn = b;
        repeat (HALF) @(posedge clk);
        #1 sclkIn = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
        s_sdo = sdoOut;
        s_oe  = sdoOeOut;
        sclkIn = 1'b0;
    endtask

    task automatic send_cmd(input logic [5:0] c);
        logic d0, d1;
        for (int i = 0; i < 6; i++) send_bit(c[i], d0, d1);
    endtask

    task automatic send_load(input logic [11:0] w);
        logic d0, d1;
        send_bit(1'b0, d0, d1);
        for (int i = 0; i < 12; i++) send_bit(w[i], d0, d1);
        send_bit(1'b1, d0, d1);
    endtask

    initial begin
        logic [13:0] rb;
        logic [13:0] oe_v;
        logic        s0, s1;
        int          wc;

        repeat (4) @(posedge clk);
        #1;
        check("rst_addr", 32'(memAddrOut), 32'h0);
        check("rst_wdata", 32'(memWrDataOut), 32'h0);
        check("rst_wen", 32'(memWrEnOut), 32'h0);
        check("rst_hold", 32'(coreHoldOut), 32'h0);
        check("rst_sdo", 32'(sdoOut), 32'h0);
        check("rst_oe", 32'(sdoOeOut), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        progEnIn = 1'b1;
        @(posedge clk) #1;
        check("hold_early", 32'(coreHoldOut), 32'h0);
        @(posedge clk) #1;
        check("hold_on", 32'(coreHoldOut), 32'h1);
        repeat (4) @(posedge clk);

        // First write: 0xA5C at address 0, single-cycle strobe.
        send_cmd(6'h02);
        send_load(12'hA5C);
        send_cmd(6'h08);
        repeat (4) @(posedge clk);
        check("wr1_count", 32'(wr_count), 32'd1);
        check("wr1_addr", 32'(last_addr), 32'h000);
        check("wr1_data", 32'(last_data), 32'hA5C);
        check("wr1_pulse", 32'(pulse_long), 32'd0);

        // Top of address space, then wrap to zero.
        for (int i = 0; i < 511; i++) send_cmd(6'h06);
        check("addr_top", 32'(memAddrOut), 32'h1FF);
        send_cmd(6'h02);
        send_load(12'h123);
        send_cmd(6'h08);
        repeat (4) @(posedge clk);
        check("wr2_count", 32'(wr_count), 32'd2);
        check("wr2_addr", 32'(last_addr), 32'h1FF);
        check("wr2_data", 32'(last_data), 32'h123);
        send_cmd(6'h06);
        check("addr_wrap", 32'(memAddrOut), 32'h000);
        send_cmd(6'h08);
        repeat (4) @(posedge clk);
        check("wr3_count", 32'(wr_count), 32'd3);
        check("wr3_addr", 32'(last_addr), 32'h000);
        check("wr3_data", 32'(last_data), 32'h123);
        check("addr_no_inc", 32'(memAddrOut), 32'h000);

        send_cmd(6'h06);
        send_cmd(6'h06);
        check("addr_two", 32'(memAddrOut), 32'h002);
        send_cmd(6'h16);
        check("addr_reset", 32'(memAddrOut), 32'h000);
        for (int i = 0; i < 5; i++) send_cmd(6'h06);
        check("addr_five", 32'(memAddrOut), 32'h005);

`ifdef LOADER_READBACK_EN
        // READ_DATA: bit0 is presented by the 6th command rise, bits 1..13 by the next 13 rises.
        for (int i = 0; i < 5; i++) send_bit(i == 2 ? 1'b1 : 1'b0, s0, s1);
        send_bit(1'b0, rb[0], oe_v[0]);
        for (int k = 1; k < 14; k++) send_bit(1'b0, rb[k], oe_v[k]);
        send_bit(1'b0, s0, s1);
        repeat (HALF) @(posedge clk);
        #1;
        check("rb_bits", 32'(rb), 32'(14'b00011110001010));
        check("rb_oe", 32'(oe_v), 32'(14'h3FFF));
        check("rb_oe_end", 32'(sdoOeOut), 32'h0);
        send_cmd(6'h06);
        check("rb_next_cmd", 32'(memAddrOut), 32'h006);
`else
        oe_v = 14'h0;
        for (int i = 0; i < 6; i++) begin
            send_bit(i == 2 ? 1'b1 : 1'b0, s0, s1);
            oe_v[i] = s1 | s0;
        end
        check("nord_oe", 32'(oe_v), 32'h0);
        send_cmd(6'h06);
        check("nord_next_cmd", 32'(memAddrOut), 32'h006);
        rb = 14'h0;
`endif

        // Abort mid-LOAD: no write, address cleared, latch keeps 0x123.
        send_cmd(6'h16);
        send_cmd(6'h06);
        check("abort_pre_addr", 32'(memAddrOut), 32'h001);
        wc = wr_count;
        send_cmd(6'h02);
        send_bit(1'b0, s0, s1);
        for (int i = 0; i < 6; i++) send_bit(i == 2 ? 1'b0 : 1'b1, s0, s1);
        @(negedge clk);
        progEnIn = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("abort_nowrite", 32'(wr_count), 32'(wc));
        check("abort_addr", 32'(memAddrOut), 32'h000);
        check("abort_hold", 32'(coreHoldOut), 32'h0);
        check("abort_oe", 32'(sdoOeOut), 32'h0);
        @(negedge clk);
        progEnIn = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("reenter_hold", 32'(coreHoldOut), 32'h1);
        send_cmd(6'h08);
        repeat (4) @(posedge clk);
        check("reenter_count", 32'(wr_count), 32'(wc + 1));
        check("reenter_addr", 32'(last_addr), 32'h000);
        check("reenter_data", 32'(last_data), 32'h123);

        // Unknown command is ignored; following INC_ADDR still decodes.
        wc = wr_count;
        send_cmd(6'h3F);
        send_cmd(6'h06);
        repeat (4) @(posedge clk);
        check("unk_addr", 32'(memAddrOut), 32'h001);
        check("unk_nowrite", 32'(wr_count), 32'(wc));
        check("pulse_width_all", 32'(pulse_long), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_mem_loader.md
# prog_mem_loader

Serial in-circuit programming loader that writes 12-bit instruction words into the program memory array. The PIC16C55 core only reads that array, through its PC-addressed port. This block is the writer on the same memory, driven by an external host over a two-wire serial link (clock and data). It also holds the core while programming is active. An optional readback path returns stored words to the host.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer flops on each serial input (min 2).
- Data width is `INST_WIDTH (12) and address width is `PC_WIDTH (9), both taken from define.v.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- progEnIn  in  1  async programming-mode request from the host pin, level-sensitive.
- sclkIn  in  1  async serial clock from the host.
- sdataIn  in  1  async serial data from the host.
- memRdDataIn  in  `INST_WIDTH  combinational read data from the program memory at memAddrOut.
- memAddrOut  out  `PC_WIDTH  program memory address for writes and readback.
- memWrDataOut  out  `INST_WIDTH  write data.
- memWrEnOut  out  1  one-cycle write strobe.
- coreHoldOut  out  1  stalls the core fetch/execute while high.
- sdoOut  out  1  serial readback data.
- sdoOeOut  out  1  output enable for the host data pin.

## Operation
- progEnIn, sclkIn and sdataIn each pass through SYNC_STAGES flops. A sclk rise is detected from the registered synchronized sclk. All actions below occur on detected rises.
- States:
  - IDLE: entered on reset or when progEn is low. Leaves to CMD when synchronized progEn goes high.
  - CMD: shifts 6 command bits, LSB first.
  - LOAD: 14 data bits.
  - READ: 14 readback bits.
  - WRITE: lasts one cycle.
- Commands, decoded after the 6th bit:
  - 0x02 LOAD_DATA → LOAD.
  - 0x04 READ_DATA → READ.
  - 0x06 INC_ADDR: addr+1, then back to CMD.
  - 0x08 BEGIN_PROG → WRITE.
  - 0x16 RESET_ADDR: addr=0, then back to CMD.
  - Any other value is ignored and the block returns to CMD.
- LOAD frame: bit0 is start (ignored), bits1..12 are data LSB first, bit13 is stop (ignored). The data latch updates only on frame completion. State then returns to CMD.
- WRITE:
  - Asserts memWrEnOut for exactly one clk, with memAddrOut = addr and memWrDataOut = data latch.
  - Then returns to CMD. The address does not auto-increment.
- READ:
  - memRdDataIn is captured into a shift register in the cycle the command is decoded.
  - sdoOeOut is high for the whole frame. sdoOut presents bit0 = 0, bits1..12 = word LSB first, bit13 = 0.
  - Each bit changes on a detected rise; the host samples on its falling edge.
- Address counter is 9 bits. It wraps from 511 to 0 on INC_ADDR.
- coreHoldOut equals the synchronized progEn.
- progEn falling in any state, including mid-frame:
  - Go to IDLE, clear addr, bit counter and shift registers.
  - Clear sdoOeOut.
  - Any WRITE not yet issued is dropped.

## Timing
- Reset values: memAddrOut=0, memWrDataOut=0, memWrEnOut=0, coreHoldOut=0, sdoOut=0, sdoOeOut=0. State is IDLE.
- A pin edge is seen SYNC_STAGES+1 clk cycles later.
- Host sclk high time and low time must each be ≥ SYNC_STAGES+2 clk periods.
- memWrEnOut rises 1 clk after the 6th BEGIN_PROG bit is detected.
- Readback capture needs memRdDataIn stable 1 clk after an address change; the protocol guarantees this.
- If a rise is detected in the same cycle progEn falls, the progEn fall wins.
- rst has priority over everything.

## Configuration
- LOADER_READBACK_EN defined: the READ_DATA command, the READ state and the sdo path are built.
- Undefined:
  - 0x04 is treated as an unknown command (ignored, return to CMD).
  - sdoOut and sdoOeOut are tied to 0.
  - No read shift register is built.

## Test plan
- Reset then progEn=1 → coreHoldOut=1 after 2 cycles. Then LOAD_DATA with word 0xA5C, BEGIN_PROG → one memWrEnOut pulse at addr 0 with data 0xA5C.
- 511 × INC_ADDR, then LOAD 0x123, BEGIN_PROG → write at 0x1FF. One more INC_ADDR, then BEGIN_PROG → write of 0x123 at 0x000 (wrap).
- With LOADER_READBACK_EN, memory returns 0x3C5 at addr 5: RESET_ADDR, 5 × INC_ADDR, READ_DATA → sdo bits 0,1,0,1,0,0,0,1,1,1,1,0,0,0, with sdoOeOut high for 14 rises.
- progEn dropped after the 7th LOAD bit → no write occurs, addr=0, coreHoldOut falls, state IDLE. Re-entering and issuing BEGIN_PROG writes the old latch value.
- Unknown command 0x3F, then INC_ADDR → addr=1 and no write. Without the macro, READ_DATA leaves sdoOeOut=0 and the following command decodes correctly.
